// File: rtl/divider_unit_if.sv
// Operand and result streams of the iterative divider.
// The divider attaches through the slave modport, the operand source through master.
interface divider_unit_if #(
  parameter int DATA_W = 32
);
  logic                  s_axis_dividend_tvalid;
  logic [DATA_W-1:0]     s_axis_dividend_tdata;
  logic                  s_axis_divisor_tvalid;
  logic [DATA_W-1:0]     s_axis_divisor_tdata;
  logic                  m_axis_dout_tvalid;
  logic [2*DATA_W-1:0]   m_axis_dout_tdata;

  modport master (
    output s_axis_dividend_tvalid,
    output s_axis_dividend_tdata,
    output s_axis_divisor_tvalid,
    output s_axis_divisor_tdata,
    input  m_axis_dout_tvalid,
    input  m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_dividend_tvalid,
    input  s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid,
    input  s_axis_divisor_tdata,
    output m_axis_dout_tvalid,
    output m_axis_dout_tdata
  );
endinterface

// File: rtl/divider_unit.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per cycle,
// followed by a sign/special-case fix-up stage and a registered one-cycle result pulse.
module divider_unit #(
  parameter int DATA_W = 32
) (
  input  logic           aclk,
  input  logic           aresetn,
  divider_unit_if.slave  dif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_W-1:0]     dividend_reg;
  logic [DATA_W-1:0]     quot_reg;
  logic [DATA_W-1:0]     dvs_mag_reg;
  logic [DATA_W-1:0]     rem_reg;
  logic                  q_neg_reg;
  logic                  r_neg_reg;
  logic                  div_zero_reg;
  logic                  ovf_reg;
  logic [DATA_W-1:0]     res_q_reg;
  logic [DATA_W-1:0]     res_r_reg;
  logic                  dout_tvalid_reg;
  logic [2*DATA_W-1:0]   dout_tdata_reg;

  logic                  accept;
  logic [DATA_W-1:0]     dvd_in;
  logic [DATA_W-1:0]     dvs_in;
  logic [DATA_W-1:0]     dvd_mag_in;
  logic [DATA_W-1:0]     dvs_mag_in;
  logic [DATA_W:0]       rem_shift;
  logic [DATA_W:0]       trial;
  logic                  trial_ok;
  logic [DATA_W-1:0]     rem_iter;
  logic [DATA_W-1:0]     q_fix;
  logic [DATA_W-1:0]     r_fix;

  assign dvd_in     = dif.s_axis_dividend_tdata;
  assign dvs_in     = dif.s_axis_divisor_tdata;
  assign accept     = (state_reg == IDLE) && dif.s_axis_dividend_tvalid && dif.s_axis_divisor_tvalid;
  assign dvd_mag_in = dvd_in[DATA_W-1] ? -dvd_in : dvd_in;
  assign dvs_mag_in = dvs_in[DATA_W-1] ? -dvs_in : dvs_in;

  // quot_reg starts as the dividend magnitude; its MSB feeds the partial remainder
  // while the new quotient bit enters at the LSB.
  assign rem_shift = {rem_reg, quot_reg[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvs_mag_reg};
  assign trial_ok  = ~trial[DATA_W];
  assign rem_iter  = trial_ok ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];

  assign q_fix = div_zero_reg ? '1 :
                 ovf_reg      ? MIN_NEG :
                 q_neg_reg    ? -quot_reg : quot_reg;
  assign r_fix = div_zero_reg ? dividend_reg :
                 ovf_reg      ? '0 :
                 r_neg_reg    ? -rem_reg : rem_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      dividend_reg    <= '0;
      quot_reg        <= '0;
      dvs_mag_reg     <= '0;
      rem_reg         <= '0;
      q_neg_reg       <= 1'b0;
      r_neg_reg       <= 1'b0;
      div_zero_reg    <= 1'b0;
      ovf_reg         <= 1'b0;
      res_q_reg       <= '0;
      res_r_reg       <= '0;
      dout_tvalid_reg <= 1'b0;
      dout_tdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          dout_tvalid_reg <= 1'b0;
          if (accept) begin
            dividend_reg <= dvd_in;
            quot_reg     <= dvd_mag_in;
            dvs_mag_reg  <= dvs_mag_in;
            rem_reg      <= '0;
            count_reg    <= '0;
            q_neg_reg    <= dvd_in[DATA_W-1] ^ dvs_in[DATA_W-1];
            r_neg_reg    <= dvd_in[DATA_W-1];
            div_zero_reg <= (dvs_in == '0);
            ovf_reg      <= (dvd_in == MIN_NEG) && (dvs_in == '1);
            state_reg    <= CALC;
          end
        end
        CALC: begin
          rem_reg   <= rem_iter;
          quot_reg  <= {quot_reg[DATA_W-2:0], trial_ok};
          count_reg <= count_reg + 1'b1;
          if (count_reg == CNT_W'(DATA_W - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          res_q_reg <= q_fix;
          res_r_reg <= r_fix;
          state_reg <= DONE;
        end
        DONE: begin
          // The pulse is visible while the FSM is already back in IDLE, so a new
          // operation can be accepted on the edge that drops it.
          dout_tdata_reg  <= {res_q_reg, res_r_reg};
          dout_tvalid_reg <= 1'b1;
          state_reg       <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dif.m_axis_dout_tvalid = dout_tvalid_reg;
  assign dif.m_axis_dout_tdata  = dout_tdata_reg;

endmodule

// File: tb/tb_divider_unit.sv
// Bench for divider_unit: directed scenarios plus random operands checked against
// plain signed-arithmetic reference results.
module tb_divider_unit;

  localparam int DATA_W = 32;
  localparam int LAT    = 34;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  divider_unit_if #(.DATA_W(DATA_W)) dif ();

  divider_unit #(.DATA_W(DATA_W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .dif     (dif.slave)
  );

  always #5 aclk = ~aclk;

  // Truncating signed division with the two defined special cases.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    q = sa / sb;
    r = sa % sb;
    return {q, r};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge aclk);
    dif.s_axis_dividend_tdata  = a;
    dif.s_axis_divisor_tdata   = b;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b1;
    @(posedge aclk);
    #1;
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    dif.s_axis_dividend_tdata  = $urandom;
    dif.s_axis_divisor_tdata   = $urandom;
  endtask

  // Watches ncyc edges; position k means "sampled just after edge E0+k".
  task automatic observe(input int ncyc, output int pulses, output int pos, output logic [63:0] data);
    pulses = 0;
    pos    = -1;
    data   = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge aclk);
      #1;
      if (dif.m_axis_dout_tvalid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          pos  = k;
          data = dif.m_axis_dout_tdata;
        end
      end
    end
  endtask

  task automatic test_reset;
    int pulses, pos;
    logic [63:0] data;
    aresetn = 1'b0;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b1;
    dif.s_axis_dividend_tdata  = 32'd11;
    dif.s_axis_divisor_tdata   = 32'd3;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (dif.m_axis_dout_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tvalid: got %b expected 0", dif.m_axis_dout_tvalid);
    end
    checks++;
    if (dif.m_axis_dout_tdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_tdata: got %h expected 0", dif.m_axis_dout_tdata);
    end
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    observe(40, pulses, pos, data);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_result: got %0d pulses expected 0", pulses);
    end
    $display("reset: pulses after release=%0d", pulses);
  endtask

  task automatic test_basic;
    int pulses, pos;
    logic [63:0] data;
    start_op(32'd100, 32'd7);
    observe(45, pulses, pos, data);
    $display("op 100/7: pulses=%0d pos=%0d q=%0d r=%0d", pulses, pos, data[63:32], data[31:0]);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    checks++;
    if (pos !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", pos, LAT); end
    checks++;
    if (data[63:32] !== 32'd14) begin errors++; $display("FAIL basic_q: got %h expected %h", data[63:32], 32'd14); end
    checks++;
    if (data[31:0] !== 32'd2) begin errors++; $display("FAIL basic_r: got %h expected %h", data[31:0], 32'd2); end
  endtask

  task automatic test_signs_special;
    logic [31:0] a_t [5] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9, 32'd5,        32'h8000_0000};
    logic [31:0] b_t [5] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0,        32'hFFFF_FFFF};
    logic [31:0] q_t [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,       32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] r_t [5] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd5,        32'd0};
    int pulses, pos;
    logic [63:0] data;
    for (int i = 0; i < 5; i++) begin
      start_op(a_t[i], b_t[i]);
      observe(40, pulses, pos, data);
      $display("op %h/%h: pulses=%0d pos=%0d q=%h r=%h", a_t[i], b_t[i], pulses, pos, data[63:32], data[31:0]);
      checks++;
      if (pulses !== 1 || pos !== LAT) begin
        errors++;
        $display("FAIL dir%0d_timing: got pulses=%0d pos=%0d expected 1 at %0d", i, pulses, pos, LAT);
      end
      checks++;
      if (data !== {q_t[i], r_t[i]}) begin
        errors++;
        $display("FAIL dir%0d_data: got %h expected %h", i, data, {q_t[i], r_t[i]});
      end
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    int pos_a [2];
    logic [63:0] dat_a [2];
    pulses = 0;
    pos_a  = '{-1, -1};
    dat_a  = '{64'h0, 64'h0};
    @(negedge aclk);
    dif.s_axis_dividend_tdata  = 32'd20;
    dif.s_axis_divisor_tdata   = 32'd3;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b1;
    @(posedge aclk);
    for (int k = 1; k <= 75; k++) begin
      @(posedge aclk);
      #1;
      if (dif.m_axis_dout_tvalid === 1'b1) begin
        if (pulses < 2) begin
          pos_a[pulses] = k;
          dat_a[pulses] = dif.m_axis_dout_tdata;
        end
        pulses++;
      end
      if (k == 5) begin
        dif.s_axis_dividend_tdata = 32'd9;
        dif.s_axis_divisor_tdata  = 32'd9;
      end
      if (k == 69) begin
        dif.s_axis_dividend_tvalid = 1'b0;
        dif.s_axis_divisor_tvalid  = 1'b0;
      end
    end
    $display("held valids: pulses=%0d pos=%0d,%0d data=%h,%h", pulses, pos_a[0], pos_a[1], dat_a[0], dat_a[1]);
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    checks++;
    if (pos_a[0] !== LAT || pos_a[1] !== LAT + 35) begin
      errors++;
      $display("FAIL b2b_timing: got %0d,%0d expected %0d,%0d", pos_a[0], pos_a[1], LAT, LAT + 35);
    end
    checks++;
    if (dat_a[0] !== {32'd6, 32'd2}) begin errors++; $display("FAIL b2b_first: got %h expected %h", dat_a[0], {32'd6, 32'd2}); end
    checks++;
    if (dat_a[1] !== {32'd1, 32'd0}) begin errors++; $display("FAIL b2b_second: got %h expected %h", dat_a[1], {32'd1, 32'd0}); end
  endtask

  task automatic test_single_valid;
    int pulses, pos;
    logic [63:0] data;
    @(negedge aclk);
    dif.s_axis_dividend_tdata  = 32'd1000;
    dif.s_axis_divisor_tdata   = 32'd3;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b0;
    observe(40, pulses, pos, data);
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL single_valid_ignored: got %0d pulses expected 0", pulses); end
    @(negedge aclk);
    dif.s_axis_dividend_tdata = 32'd50;
    dif.s_axis_divisor_tdata  = 32'd7;
    dif.s_axis_divisor_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    observe(40, pulses, pos, data);
    $display("op 50/7 after lone valid: pulses=%0d pos=%0d data=%h", pulses, pos, data);
    checks++;
    if (pulses !== 1 || pos !== LAT) begin
      errors++;
      $display("FAIL single_then_both_timing: got pulses=%0d pos=%0d expected 1 at %0d", pulses, pos, LAT);
    end
    checks++;
    if (data !== {32'd7, 32'd1}) begin errors++; $display("FAIL single_then_both_data: got %h expected %h", data, {32'd7, 32'd1}); end
  endtask

  task automatic test_reset_abort;
    int pulses, pos;
    logic [63:0] data;
    start_op(32'd1000, 32'd3);
    observe(9, pulses, pos, data);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if (dif.m_axis_dout_tvalid !== 1'b0 || dif.m_axis_dout_tdata !== 64'h0) begin
      errors++;
      $display("FAIL abort_reset_outputs: got tvalid=%b tdata=%h expected 0/0", dif.m_axis_dout_tvalid, dif.m_axis_dout_tdata);
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    observe(40, pulses, pos, data);
    $display("aborted op 1000/3: pulses after reset=%0d", pulses);
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_no_result: got %0d pulses expected 0", pulses); end
    start_op(32'hFFFF_FFF7, 32'd4);
    observe(40, pulses, pos, data);
    $display("op -9/4 after abort: pulses=%0d pos=%0d data=%h", pulses, pos, data);
    checks++;
    if (pulses !== 1 || pos !== LAT) begin
      errors++;
      $display("FAIL abort_recover_timing: got pulses=%0d pos=%0d expected 1 at %0d", pulses, pos, LAT);
    end
    checks++;
    if (data !== {32'hFFFF_FFFE, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL abort_recover_data: got %h expected %h", data, {32'hFFFF_FFFE, 32'hFFFF_FFFF});
    end
  endtask

  task automatic test_random;
    int pulses, pos;
    logic [63:0] data;
    logic [63:0] exp;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 15));
        1: b = -32'($urandom_range(1, 15));
        2: b = 32'h0;
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp = ref_div(a, b);
      start_op(a, b);
      observe(40, pulses, pos, data);
      $display("rand %0d: %0d / %0d -> q=%0d r=%0d", i, $signed(a), $signed(b), $signed(data[63:32]), $signed(data[31:0]));
      checks++;
      if (pulses !== 1 || pos !== LAT) begin
        errors++;
        $display("FAIL rand%0d_timing: got pulses=%0d pos=%0d expected 1 at %0d", i, pulses, pos, LAT);
      end
      checks++;
      if (data !== exp) begin
        errors++;
        $display("FAIL rand%0d_data: got %h expected %h", i, data, exp);
      end
    end
  endtask

  initial begin
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    dif.s_axis_dividend_tdata  = '0;
    dif.s_axis_divisor_tdata   = '0;
    test_reset();
    test_basic();
    test_signs_special();
    test_back_to_back();
    test_single_valid();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Iterative signed 32-bit integer divider: one division at a time, fixed latency.
- Sits under the execution-stage divide functional unit.
- Operands arrive on two valid-qualified streams; the result leaves on a valid-qualified stream.
- There is no backpressure (no tready on any channel).

Parameters:
- DATA_W, 32: operand width. Output is 2*DATA_W bits. All values below assume 32.

Ports:
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tdata  in  32  dividend, two's complement.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tdata  in  32  divisor, two's complement.
- m_axis_dout_tvalid  out  1  result valid, one-cycle pulse.
- m_axis_dout_tdata  out  64  [63:32] = quotient, [31:0] = remainder.

Behaviour:
- Reset is asynchronous, asserted by aresetn=0:
  - State goes to IDLE.
  - m_axis_dout_tvalid=0 and m_axis_dout_tdata=0.
  - Any in-flight division is discarded; no result is ever produced for it.
- States:
  - IDLE → CALC when both tvalids are 1 at a rising edge; both tdata values are captured on that edge (acceptance edge E0).
  - CALC: 32 restoring-division iterations, one quotient bit per cycle, on unsigned magnitudes.
  - FIX: apply signs and special cases, then register the output.
  - DONE: m_axis_dout_tvalid=1 for exactly one cycle, then return to IDLE.
- Latency: m_axis_dout_tvalid is high during the cycle following edge E0+34 and falls at edge E0+35. The next acceptance is possible at edge E0+35 at the earliest.
- Input acceptance:
  - Inputs are sampled only in IDLE.
  - Both valids must be high in the same cycle; a single valid alone is ignored and nothing is latched.
  - Valids held high during CALC/FIX/DONE are ignored and do not queue a second operation.
  - Input tdata may change freely after E0.
- Arithmetic (truncating signed division):
  - Quotient rounds toward zero.
  - Remainder takes the sign of the dividend.
  - dividend = quotient*divisor + remainder.
- Special cases:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Dividend 0x80000000 with divisor 0xFFFFFFFF (overflow): quotient 0x80000000, remainder 0.
- m_axis_dout_tdata holds the last result after the tvalid pulse until the next result or reset. Consumers must qualify it with tvalid.
- Expected size: roughly 150–250 lines of RTL.

Test Plan:
- Reset then 100/7 (both valids at E0) → tvalid single pulse after E0+34; tdata[63:32]=14, [31:0]=2; tvalid=0 in every other cycle.
- Signs, one at a time:
  - -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7/-2 → quotient 0xFFFFFFFD, remainder 1.
  - -7/-2 → quotient 3, remainder 0xFFFFFFFF.
- Special cases:
  - 5/0 → quotient 0xFFFFFFFF, remainder 5.
  - 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Valids held high continuously with 20/3, changing tdata to 9/9 at E0+5 → exactly one pulse per 35 cycles; first result is q=6, r=2; second operation is accepted at E0+35 and returns q=1, r=0.
- Only dividend_tvalid high for 10 cycles → no result ever. Then divisor_tvalid also high → normal 34-cycle result.
- aresetn pulsed low at E0+10 → tvalid stays 0 and no result appears for the aborted operation; a new operation after reset completes normally.
